// File: rtl/pixel_array_ctrl.sv
// Frame controller for an N_ROWS x N_COLS pixel sensor array.
// It sequences the global erase, expose, convert and readout phases and
// drives the shared ramp code during conversion. Readout captures one row at
// a time from the column buses and streams pixels on a valid/ready port.
// Every output is a flop. Each output is loaded from a value decoded from the
// next state, so an output changes on the same edge as the state it reflects.
module pixel_array_ctrl #(
  parameter int N_ROWS   = 2,
  parameter int N_COLS   = 2,
  parameter int ADC_BITS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic                                          continuous,
  input  logic [CNT_W-1:0]                              t_erase,
  input  logic [CNT_W-1:0]                              t_expose,
  output logic                                          erase,
  output logic                                          expose,
  output logic                                          convert,
  output logic [ADC_BITS-1:0]                           adc_code,
  output logic [N_ROWS-1:0]                             row_sel,
  input  logic [N_COLS*ADC_BITS-1:0]                    pix_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [ADC_BITS-1:0]                           out_data,
  output logic [((N_ROWS > 1) ? $clog2(N_ROWS) : 1)-1:0] out_row,
  output logic [((N_COLS > 1) ? $clog2(N_COLS) : 1)-1:0] out_col,
  output logic                                          frame_done,
  output logic                                          busy
);

  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [RW-1:0]       LAST_ROW = RW'(N_ROWS - 1);
  localparam logic [CW-1:0]       LAST_COL = CW'(N_COLS - 1);
  localparam logic [ADC_BITS-1:0] ADC_MAX  = '1;
  // Two cycles in READ_ROW: the counter is loaded with 1 and the capture
  // happens when it reaches 0.
  localparam logic [CNT_W-1:0]    ROW_CYC  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ERASE    = 3'd1,
    EXPOSE   = 3'd2,
    CONVERT  = 3'd3,
    READ_ROW = 3'd4,
    OUTPUT   = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [RW-1:0]       row, row_d;
  logic [CW-1:0]       col, col_d;
  logic [ADC_BITS-1:0] row_buf [N_COLS];

  logic                erase_d, expose_d, convert_d;
  logic [ADC_BITS-1:0] adc_d;
  logic [N_ROWS-1:0]   row_sel_d;
  logic                out_valid_d;
  logic [ADC_BITS-1:0] out_data_d;
  logic [RW-1:0]       out_row_d;
  logic [CW-1:0]       out_col_d;
  logic                frame_done_d, busy_d;
  logic                capture;

  // Converts a programmed duration into a down-counter preload.
  // A duration of 0 runs for one cycle, the same as a duration of 1.
  function automatic logic [CNT_W-1:0] phase_preload(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // The row buffer is loaded on the edge that ends the second READ_ROW cycle.
  assign capture = (state == READ_ROW) && (cnt == '0);

  // Next-state, counter and index decisions.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    row_d   = row;
    col_d   = col;
    adc_d   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = ERASE;
          cnt_d   = phase_preload(t_erase);
        end
      end
      ERASE: begin
        if (cnt == '0) begin
          state_d = EXPOSE;
          cnt_d   = phase_preload(t_expose);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      EXPOSE: begin
        if (cnt == '0) begin
          // adc_d keeps its default of 0, so the ramp starts at code 0.
          state_d = CONVERT;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      CONVERT: begin
        // adc_code is the conversion counter. The last code ends the phase,
        // and the default of 0 returns the code to 0 on exit.
        if (adc_code == ADC_MAX) begin
          state_d = READ_ROW;
          row_d   = '0;
          cnt_d   = ROW_CYC;
        end else begin
          adc_d = adc_code + 1'b1;
        end
      end
      READ_ROW: begin
        if (cnt == '0) begin
          state_d = OUTPUT;
          col_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      OUTPUT: begin
        // out_valid is always high in OUTPUT, so out_ready alone means a transfer.
        if (out_ready) begin
          if (col == LAST_COL) begin
            if (row == LAST_ROW) begin
              state_d = DONE;
            end else begin
              state_d = READ_ROW;
              row_d   = row + 1'b1;
              cnt_d   = ROW_CYC;
            end
          end else begin
            col_d = col + 1'b1;
          end
        end
      end
      DONE: begin
        if (continuous) begin
          state_d = ERASE;
          cnt_d   = phase_preload(t_erase);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values decoded from the next state, ready to be registered.
  always_comb begin
    erase_d      = (state_d == ERASE);
    expose_d     = (state_d == EXPOSE);
    convert_d    = (state_d == CONVERT);
    frame_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
    out_valid_d  = (state_d == OUTPUT);
    row_sel_d    = '0;
    out_data_d   = '0;
    out_row_d    = '0;
    out_col_d    = '0;
    if (state_d == READ_ROW) begin
      row_sel_d[row_d] = 1'b1;
    end
    if (state_d == OUTPUT) begin
      out_row_d = row_d;
      out_col_d = col_d;
      // On the capture edge the buffer is not loaded yet, so the first word
      // is taken straight from the column buses.
      if (capture) begin
        out_data_d = pix_data[int'(col_d)*ADC_BITS +: ADC_BITS];
      end else begin
        out_data_d = row_buf[col_d];
      end
    end
  end

  // State, phase counter and readout indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      row   <= row_d;
      col   <= col_d;
    end
  end

  // Row buffer holding the N_COLS words of the row being streamed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_COLS; c++) row_buf[c] <= '0;
    end else if (capture) begin
      for (int c = 0; c < N_COLS; c++) row_buf[c] <= pix_data[c*ADC_BITS +: ADC_BITS];
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      adc_code   <= '0;
      row_sel    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      erase      <= erase_d;
      expose     <= expose_d;
      convert    <= convert_d;
      adc_code   <= adc_d;
      row_sel    <= row_sel_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_row    <= out_row_d;
      out_col    <= out_col_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
- Parametrised frame controller for an N_ROWS x N_COLS pixel sensor array.
- Sequences the global erase, expose, convert and readout phases.
- Drives the shared digital ramp code during conversion.
- Reads the array row by row over per-column tristate buses and streams one pixel per transfer on a valid/ready output port.
- Supports single-shot and continuous frame modes, with run-time programmable phase durations.

Parameters:
- N_ROWS, 2, number of pixel rows (>=1)
- N_COLS, 2, number of pixel columns (>=1)
- ADC_BITS, 8, ramp/pixel code width; conversion lasts 2^ADC_BITS cycles
- CNT_W, 16, width of phase-duration inputs and internal phase counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- continuous  in  1  1: restart ERASE after each frame; 0: return to IDLE
- t_erase  in  CNT_W  erase duration in cycles (0 treated as 1)
- t_expose  in  CNT_W  expose duration in cycles (0 treated as 1)
- erase  out  1  global pixel erase
- expose  out  1  global pixel expose
- convert  out  1  ramp enable to analog ramp generator
- adc_code  out  ADC_BITS  digital ramp code broadcast to pixels
- row_sel  out  N_ROWS  one-hot row read enable
- pix_data  in  N_COLS*ADC_BITS  column buses; column c at bits [c*ADC_BITS +: ADC_BITS]
- out_valid  out  1  pixel word available
- out_ready  in  1  sink accepts word
- out_data  out  ADC_BITS  pixel code
- out_row  out  max(1,$clog2(N_ROWS))  row index of out_data
- out_col  out  max(1,$clog2(N_COLS))  column index of out_data
- frame_done  out  1  one-cycle pulse after last pixel accepted
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous. All outputs go to 0, state goes to IDLE, and counters and the row buffer are cleared. Reset mid-frame aborts the frame; no frame_done is issued.
- All outputs are registered; the state takes effect on the edge after the decision.
- IDLE:
  - If start=1 at a posedge: next state ERASE.
  - start in any other state is ignored.
- ERASE:
  - erase=1 for exactly max(t_erase,1) cycles, then EXPOSE.
  - t_erase is sampled on entry.
- EXPOSE:
  - expose=1 for exactly max(t_expose,1) cycles, then CONVERT.
  - t_expose is sampled on entry.
- CONVERT:
  - convert=1 for 2^ADC_BITS cycles.
  - adc_code=0 in the first cycle and increments by 1 each cycle, reaching 2^ADC_BITS-1 in the last cycle (no wrap inside the phase).
  - Next state READ_ROW with row index r=0.
  - adc_code returns to 0 on exit.
- READ_ROW:
  - row_sel[r]=1 for 2 cycles. Cycle 1 is bus settle. At the end of cycle 2, all N_COLS words of pix_data are captured into the row buffer.
  - Next state OUTPUT with c=0.
  - row_sel is all-zero in every other state, and at most one bit is ever set.
- OUTPUT:
  - out_valid=1, out_data=buf[c], out_row=r, out_col=c.
  - A transfer occurs on a posedge with out_valid & out_ready. On transfer, c increments.
  - After the transfer of c=N_COLS-1: if r<N_ROWS-1, r increments and the next state is READ_ROW; otherwise the next state is DONE.
  - While out_ready=0, out_data/out_row/out_col hold stable. There is no timeout.
  - out_valid drops in the cycle after the last column's transfer of each row.
- DONE:
  - frame_done=1 for one cycle.
  - Next state ERASE if continuous=1 (sampled in DONE), else IDLE.
- erase, expose, convert and row_sel are mutually exclusive at all times.
- Frame length with out_ready tied high: max(t_erase,1) + max(t_expose,1) + 2^ADC_BITS + N_ROWS*(2+N_COLS) + 1 cycles (DONE included), plus 1 IDLE->ERASE cycle.

Test Plan:
- N_ROWS=2, N_COLS=2, ADC_BITS=4, t_erase=3, t_expose=5, out_ready=1, pix_data row0={0x3,0xA}, row1={0xF,0x0}, one start pulse -> erase high 3 cycles, expose high 5 cycles, convert high 16 cycles with adc_code 0..15; output sequence (r,c,data) = (0,0,0x3), (0,1,0xA), (1,0,0xF), (1,1,0x0); one frame_done pulse; return to IDLE with busy=0.
- Same setup, out_ready low for 4 cycles while out_valid=1 at (0,1) -> outputs hold 0xA/(0,1) unchanged; exactly 4 transfers total; no duplicate or dropped word.
- t_erase=0, t_expose=0 -> erase and expose each high exactly 1 cycle.
- continuous=1 for 2 frames -> second erase asserted the cycle after frame_done; start pulses during busy have no effect; 8 words total.
- reset asserted asynchronously mid-CONVERT (adc_code=7) -> all outputs 0 immediately; IDLE; no frame_done; a new start runs a full clean frame.
- Invariant checker over all runs: erase/expose/convert/row_sel one-hot-or-zero; row_sel high exactly 2 cycles per row.
